// File: rtl/sha256_stream.sv
// Multi-chunk SHA-256/SHA-224 engine: accepts pre-padded 512-bit chunks as 16 words,
// runs 64 rounds per chunk and chains H0..H7 until the chunk flagged last.
`timescale 1ns/1ps

module sha256_k (
   input  logic [5:0]  addr,
   output logic [31:0] k
);
   localparam logic [31:0] K_TABLE [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };
   assign k = K_TABLE[addr];
endmodule

module sha256_stream #(
   parameter int BYTE_SWAP = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         abort_i,
   input  logic         dat_valid_i,
   output logic         dat_ready_o,
   input  logic [31:0]  dat_i,
   input  logic         dat_last_i,
   input  logic         mode_224_i,
   output logic [255:0] digest_o,
   output logic         digest_valid_o,
   output logic         busy_o
);
   typedef enum logic [2:0] {IDLE, LOAD, PROC, UPDATE, DONE} state_t;

   localparam logic [31:0] IV256 [8] = '{
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
   localparam logic [31:0] IV224 [8] = '{
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   state_t      state, state_next;
   logic [31:0] h [8];
   logic [31:0] wv [8];
   logic [31:0] w [16];
   logic [31:0] h_sum [8];
   logic [3:0]  count;
   logic [5:0]  round_cnt;
   logic        last_q, mode_q;
   logic        accept;
   logic [31:0] word, k_t, t1, t2, w_new;

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   sha256_k u_k (.addr(round_cnt), .k(k_t));

   assign dat_ready_o = ~rst & ~abort_i & ((state == IDLE) | (state == LOAD));
   assign accept      = dat_valid_i & dat_ready_o;
   assign busy_o      = (state != IDLE);
   assign word        = (BYTE_SWAP != 0) ? {dat_i[7:0], dat_i[15:8], dat_i[23:16], dat_i[31:24]}
                                         : dat_i;

   // One compression round; w[0] always holds W[t] because the schedule shifts each round.
   always_comb begin
      t1 = wv[7] + (rotr(wv[4], 6) ^ rotr(wv[4], 11) ^ rotr(wv[4], 25))
         + ((wv[4] & wv[5]) ^ (~wv[4] & wv[6])) + k_t + w[0];
      t2 = (rotr(wv[0], 2) ^ rotr(wv[0], 13) ^ rotr(wv[0], 22))
         + ((wv[0] & wv[1]) ^ (wv[0] & wv[2]) ^ (wv[1] & wv[2]));
      w_new = (rotr(w[14], 17) ^ rotr(w[14], 19) ^ (w[14] >> 10)) + w[9]
            + (rotr(w[1], 7) ^ rotr(w[1], 18) ^ (w[1] >> 3)) + w[0];
      for (int i = 0; i < 8; i++) h_sum[i] = h[i] + wv[i];
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = LOAD;
         LOAD:    if (accept && count == 4'd15) state_next = PROC;
         PROC:    if (round_cnt == 6'd63) state_next = UPDATE;
         UPDATE:  state_next = last_q ? DONE : LOAD;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      if (abort_i) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Abort clears the message context but leaves digest_o and H alone; H is reloaded from the IV on the next first word.
   always_ff @(posedge clk) begin
      if (rst) begin
         count          <= 4'd0;
         round_cnt      <= 6'd0;
         last_q         <= 1'b0;
         mode_q         <= 1'b0;
         digest_o       <= '0;
         digest_valid_o <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            h[i]  <= 32'd0;
            wv[i] <= 32'd0;
         end
         for (int i = 0; i < 16; i++) w[i] <= 32'd0;
      end else if (abort_i) begin
         count          <= 4'd0;
         round_cnt      <= 6'd0;
         last_q         <= 1'b0;
         mode_q         <= 1'b0;
         digest_valid_o <= 1'b0;
         for (int i = 0; i < 16; i++) w[i] <= 32'd0;
      end else begin
         digest_valid_o <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               w[0]   <= word;
               count  <= 4'd1;
               mode_q <= mode_224_i;
               for (int i = 0; i < 8; i++) h[i] <= mode_224_i ? IV224[i] : IV256[i];
            end
            LOAD: if (accept) begin
               w[count] <= word;
               count    <= count + 4'd1;
               if (count == 4'd15) begin
                  last_q    <= dat_last_i;
                  round_cnt <= 6'd0;
                  for (int i = 0; i < 8; i++) wv[i] <= h[i];
               end
            end
            PROC: begin
               for (int i = 0; i < 15; i++) w[i] <= w[i+1];
               w[15]     <= w_new;
               round_cnt <= round_cnt + 6'd1;
               wv[0] <= t1 + t2;
               wv[1] <= wv[0];
               wv[2] <= wv[1];
               wv[3] <= wv[2];
               wv[4] <= wv[3] + t1;
               wv[5] <= wv[4];
               wv[6] <= wv[5];
               wv[7] <= wv[6];
            end
            UPDATE: begin
               for (int i = 0; i < 8; i++) h[i] <= h_sum[i];
               count <= 4'd0;
               if (last_q) begin
                  digest_o <= {h_sum[0], h_sum[1], h_sum[2], h_sum[3], h_sum[4],
                               h_sum[5], h_sum[6], mode_q ? 32'd0 : h_sum[7]};
                  digest_valid_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule
